// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, wrap or saturate at the range ends,
// synchronous clear/load, and terminal-count / overflow reporting.
module mod_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int SATURATE    = 0,
  parameter int PRESCALE    = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sticky_clear,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             overflow_sticky,
  output logic             load_error,
  output logic             at_max,
  output logic             at_min
);

  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [PS_W-1:0] ps;
  logic            ps_wrap;
  logic            step_now;
  logic [WIDTH:0]  step_res;
  logic            term_evt;
  logic            load_ok;

  // Range ends are detected before any arithmetic, so the count can never
  // leave 0..MODULUS-1 even when MODULUS fills the whole WIDTH.
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] cur,
                                             input logic             dir);
    logic [WIDTH-1:0] nxt;
    logic             term;
    term = 1'b0;
    nxt  = cur;
    if (dir) begin
      if (cur == MAX_VAL) begin
        term = 1'b1;
        nxt  = (SATURATE != 0) ? cur : '0;
      end else begin
        nxt = cur + WIDTH'(1);
      end
    end else begin
      if (cur == '0) begin
        term = 1'b1;
        nxt  = (SATURATE != 0) ? cur : MAX_VAL;
      end else begin
        nxt = cur - WIDTH'(1);
      end
    end
    return {term, nxt};
  endfunction

  assign ps_wrap  = (ps == PS_LAST);
  assign step_now = !clear && !load && enable && ps_wrap;
  assign step_res = step_fn(count, up_down);
  assign term_evt = step_now && step_res[WIDTH];
  assign load_ok  = ({1'b0, load_value} < MOD_EXT);

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count           <= RST_VAL;
      ps              <= '0;
      terminal        <= 1'b0;
      overflow_sticky <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      terminal   <= term_evt;
      load_error <= 1'b0;
      if (clear) begin
        count <= '0;
        ps    <= '0;
      end else if (load) begin
        ps <= '0;
        if (load_ok) begin
          count <= load_value;
        end else begin
          count      <= MAX_VAL;
          load_error <= 1'b1;
        end
      end else if (enable) begin
        if (ps_wrap) begin
          ps    <= '0;
          count <= step_res[WIDTH-1:0];
        end else begin
          ps <= ps + PS_W'(1);
        end
      end
      // A terminal event on the same edge as sticky_clear keeps the flag set.
      if (term_evt) begin
        overflow_sticky <= 1'b1;
      end else if (sticky_clear) begin
        overflow_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three configurations driven in lockstep,
// each compared against a behavioural model of the counting rules.
module tb_mod_counter;

  localparam int N = 3;
  localparam int MODS [N] = '{16, 10, 10};
  localparam int SATS [N] = '{0, 0, 1};
  localparam int PRES [N] = '{1, 3, 1};
  localparam int RSTV [N] = '{0, 0, 3};

  logic       clock = 1'b0;
  logic       reset;
  logic       enable, up_down, clear, load, sticky_clear;
  logic [3:0] load_value;

  logic [3:0] cnt  [N];
  logic       term [N];
  logic       stk  [N];
  logic       lerr [N];
  logic       amax [N];
  logic       amin [N];

  typedef struct {
    int cnt;
    int ps;
    bit sticky;
  } st_t;

  typedef struct {
    int cnt  [N];
    bit term [N];
    bit stk  [N];
    bit lerr [N];
  } exp_t;

  st_t  st [N];
  exp_t sb_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1), .RESET_VALUE(0)) u_wrap16 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .sticky_clear(sticky_clear),
    .count(cnt[0]), .terminal(term[0]), .overflow_sticky(stk[0]), .load_error(lerr[0]),
    .at_max(amax[0]), .at_min(amin[0]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3), .RESET_VALUE(0)) u_wrap10_ps3 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .sticky_clear(sticky_clear),
    .count(cnt[1]), .terminal(term[1]), .overflow_sticky(stk[1]), .load_error(lerr[1]),
    .at_max(amax[1]), .at_min(amin[1]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1), .RESET_VALUE(3)) u_sat10 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .sticky_clear(sticky_clear),
    .count(cnt[2]), .terminal(term[2]), .overflow_sticky(stk[2]), .load_error(lerr[2]),
    .at_max(amax[2]), .at_min(amin[2]));

  function automatic void check(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, inst, $time, act, exp);
    end
  endfunction

  // Counting rules in plain arithmetic: modulo for wrap, clamping for saturate.
  function automatic void model(input int i, input bit en, input bit ud, input bit clr,
                                input bit ld, input int lv, input bit sc,
                                output int c, output bit t, output bit s, output bit le);
    int m;
    m  = MODS[i];
    t  = 1'b0;
    le = 1'b0;
    if (clr) begin
      st[i].cnt = 0;
      st[i].ps  = 0;
    end else if (ld) begin
      st[i].ps = 0;
      if (lv < m) st[i].cnt = lv;
      else begin
        st[i].cnt = m - 1;
        le = 1'b1;
      end
    end else if (en) begin
      st[i].ps = st[i].ps + 1;
      if (st[i].ps == PRES[i]) begin
        st[i].ps = 0;
        t = ud ? (st[i].cnt == m - 1) : (st[i].cnt == 0);
        if (SATS[i] != 0) st[i].cnt = ud ? ((st[i].cnt + 1 > m - 1) ? m - 1 : st[i].cnt + 1)
                                         : ((st[i].cnt - 1 < 0) ? 0 : st[i].cnt - 1);
        else st[i].cnt = ud ? (st[i].cnt + 1) % m : (st[i].cnt + m - 1) % m;
      end
    end
    if (t) st[i].sticky = 1'b1;
    else if (sc) st[i].sticky = 1'b0;
    c = st[i].cnt;
    s = st[i].sticky;
  endfunction

  task automatic cycle(input bit en, input bit ud, input bit clr, input bit ld,
                       input int lv, input bit sc);
    exp_t e;
    @(negedge clock);
    enable       = en;
    up_down      = ud;
    clear        = clr;
    load         = ld;
    load_value   = 4'(lv);
    sticky_clear = sc;
    for (int i = 0; i < N; i++) model(i, en, ud, clr, ld, lv, sc, e.cnt[i], e.term[i], e.stk[i], e.lerr[i]);
    sb_q.push_back(e);
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      st[i].cnt    = RSTV[i];
      st[i].ps     = 0;
      st[i].sticky = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check({tag, "_count"}, i, int'(cnt[i]), RSTV[i]);
      check({tag, "_terminal"}, i, int'(term[i]), 0);
      check({tag, "_sticky"}, i, int'(stk[i]), 0);
      check({tag, "_load_error"}, i, int'(lerr[i]), 0);
    end
  endtask

  // Monitor: the counter presents a result every edge; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < N; i++) begin
          check("count", i, int'(cnt[i]), e.cnt[i]);
          check("terminal", i, int'(term[i]), int'(e.term[i]));
          check("sticky", i, int'(stk[i]), int'(e.stk[i]));
          check("load_error", i, int'(lerr[i]), int'(e.lerr[i]));
          check("at_max", i, int'(amax[i]), int'(e.cnt[i] == MODS[i] - 1));
          check("at_min", i, int'(amin[i]), int'(e.cnt[i] == 0));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    {enable, up_down, clear, load, sticky_clear} = '0;
    load_value = '0;
    reset_model();
    repeat (2) @(negedge clock);
    check_reset_state("por");
    reset = 1'b0;

    // Free-running up count through a full wrap of the 16-range counter
    for (int k = 0; k < 17; k++) cycle(1, 1, 0, 0, 0, 0);
    // Down from 0 across the wrap, long enough for prescaled steps too
    cycle(0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 9; k++) cycle(1, 0, 0, 0, 0, 0);
    // Saturation at the top, then sticky_clear racing a terminal event
    cycle(0, 1, 0, 1, 8, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    // Prescaler phase frozen while enable is low
    cycle(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 0, 0);
    // Out-of-range load, load vs clear priority, load while stepping
    cycle(0, 1, 0, 1, 12, 0);
    cycle(1, 1, 1, 1, 7, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 5, 0);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 15, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges, mid-count and mid-prescale
    cycle(0, 1, 0, 1, 6, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 0, 0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    reset_model();
    #1;
    check_reset_state("async");
    reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 32) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 15), $urandom_range(0, 9) == 0);
    end

    @(posedge clock);
    #2;
    check("scoreboard_drained", 0, sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised modulo up/down counter, the successor to the team's fixed 4-bit free-running counter. It adds configurable width and modulus, wrap or saturate mode, a clock prescaler, synchronous load and clear, and terminal-count reporting. It is used as the general-purpose event and timebase counter in the testing environment and datapath blocks.

Parameters:
WIDTH, 4, counter width in bits.
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.
PRESCALE, 1, number of enabled cycles per count step; must be >= 1.
RESET_VALUE, 0, value of count after reset; must be < MODULUS.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  qualifies prescaler advance and count steps.
up_down  input  1  1 = count up, 0 = count down; sampled on step cycles.
clear  input  1  synchronous clear to 0.
load  input  1  synchronous load of load_value.
load_value  input  WIDTH  value to load.
sticky_clear  input  1  clears overflow_sticky.
count  output  WIDTH  current count, registered.
terminal  output  1  registered one-cycle pulse on a wrap or saturate event.
overflow_sticky  output  1  set by any terminal event; held until cleared.
load_error  output  1  registered one-cycle pulse when load_value >= MODULUS.
at_max  output  1  combinational: count == MODULUS-1.
at_min  output  1  combinational: count == 0.

Behaviour:
- Reset (asynchronous, active-high) is decided for this block; the clock port is named clock and the reset port reset. On reset: count=RESET_VALUE, prescaler=0, terminal=0, overflow_sticky=0, load_error=0.
- Priority on each rising edge: clear > load > step.
- clear: count=0, prescaler=0, terminal=0.
- load:
  - If load_value < MODULUS: count=load_value.
  - Otherwise: count=MODULUS-1 and load_error=1 for one cycle.
  - In both cases: prescaler=0, terminal=0.
- Prescaler: internal counter ps, range 0..PRESCALE-1.
  - enable=0: ps and count hold.
  - enable=1 and ps<PRESCALE-1: ps increments; no step.
  - enable=1 and ps==PRESCALE-1: ps=0 and a step occurs.
  - PRESCALE=1: every enabled cycle is a step.
- Step, up direction:
  - count<MODULUS-1: count+1.
  - count==MODULUS-1, SATURATE=0: count=0, terminal event.
  - count==MODULUS-1, SATURATE=1: hold, terminal event.
- Step, down direction: mirrors the up direction at 0 (wraps to MODULUS-1 or holds).
- Arithmetic: compare against MODULUS before incrementing, so the count never exceeds MODULUS-1 even when MODULUS=2^WIDTH. No intermediate value is wider than WIDTH+1.
- Timing:
  - terminal asserts in the same edge as the step that causes it and lasts exactly one cycle.
  - Every saturated step attempt produces its own terminal pulse.
  - Step latency: count reflects the step immediately after the qualifying edge (1 cycle from enable sampled high).
- overflow_sticky:
  - Set on any terminal event.
  - Cleared by sticky_clear.
  - If both occur on the same edge, set wins.
- up_down changes take effect on the next step; the prescaler phase is not affected.
- Reset asserted mid-count or mid-prescale returns everything to reset values immediately. Counting resumes on the first rising edge after reset deasserts.

Test Plan:
- Defaults, enable=1, up, 17 cycles from 0 -> count sequence 1..15, 0, 1; terminal pulses once, at the 0 transition; overflow_sticky=1.
- WIDTH=4, MODULUS=10, down, start 0, 3 steps -> count 9, 8, 7; terminal on the first step only; at_max=1 while count=9.
- SATURATE=1, MODULUS=10, up from 8, 4 steps -> 9, 9, 9, 9; terminal on steps 2, 3 and 4; then sticky_clear and a step on the same edge -> overflow_sticky stays 1.
- PRESCALE=3, enable held high for 9 cycles -> count 3; enable toggled off for 2 cycles mid-phase -> count and phase frozen.
- MODULUS=10, load with load_value=12 -> count=9, load_error pulse; load and clear on the same edge -> count=0; load with load_value=5 while stepping -> count=5 and prescaler restarts.
- reset pulsed asynchronously between edges while count=7 and ps=1 -> count=RESET_VALUE and all flags 0 before the next edge.
